// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the 8-bit synchronous FIFO: pops words through rd/empty/data_out
// and re-presents them as a bubble-free valid/ready stream through a small skid buffer.
module fifo_stream_reader #(
  parameter  int DW        = 8,
  parameter  int BUF_DEPTH = 2,
  parameter  int CNT_W     = 16,
  localparam int OCC_W     = $clog2(BUF_DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_fifo_empty,
  input  logic [DW-1:0]    i_fifo_data,
  output logic             o_fifo_rd,
  output logic             o_m_valid,
  output logic [DW-1:0]    o_m_data,
  input  logic             i_m_ready,
  output logic [OCC_W-1:0] o_occupancy,
  output logic [CNT_W-1:0] o_word_cnt
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int LVL_W = OCC_W + 1;

  logic [OCC_W-1:0] r_occ;
  logic             r_inflight;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_word_cnt;
  logic [DW-1:0]    r_buf [BUF_DEPTH];

  logic             w_pop;
  logic             w_capture;
  logic [LVL_W-1:0] w_level;
  logic             w_has_room;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop     = (r_occ != '0) && i_m_ready;
  assign w_capture = r_inflight && !i_flush;

  // Committed level counts the word already in flight and credits a same-cycle pop,
  // which is what lets the buffer sustain one word per clock.
  assign w_level    = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight} - {{OCC_W{1'b0}}, w_pop};
  assign w_has_room = w_level < LVL_W'(BUF_DEPTH);

  assign o_fifo_rd   = i_rst_n && !i_flush && !i_fifo_empty && w_has_room;
  assign o_m_valid   = (r_occ != '0);
  assign o_m_data    = r_buf[r_head];
  assign o_occupancy = r_occ;
  assign o_word_cnt  = r_word_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_word_cnt <= '0;
    end else begin
      if (i_flush) begin
        r_occ      <= '0;
        r_inflight <= 1'b0;
        r_head     <= '0;
        r_tail     <= '0;
      end else begin
        r_inflight <= o_fifo_rd;
        if (w_capture) r_tail <= next_ptr(r_tail);
        if (w_pop)     r_head <= next_ptr(r_head);
        if (w_capture && !w_pop)      r_occ <= r_occ + OCC_W'(1);
        else if (!w_capture && w_pop) r_occ <= r_occ - OCC_W'(1);
      end
      // A pop in the flush cycle was accepted downstream, so it still counts.
      if (w_pop) r_word_cnt <= r_word_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_capture) r_buf[r_tail] <= i_fifo_data;
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_capture && !w_pop && (r_occ == OCC_W'(BUF_DEPTH))));

endmodule
